// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_unit_pkg;

    localparam int unsigned xlen        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DRAIN
    } ifetch_state_e;

    typedef struct packed {
        logic [xlen-1:0] pc;
        logic [xlen-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetch entries toward decode; head is held in a register
// so a pushed entry is visible the cycle after it is written.
module ifetch_fifo
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    fetch_entry_t    head_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_inc;
    logic [CW-1:0]   count_reg;

    assign rd_ptr_inc = rd_ptr_reg + PW'(1);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else if (clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_inc;
            count_reg <= count_reg + CW'(push) - CW'(pop);
            // Next head comes from storage if it is already there, else from the incoming entry.
            if (pop && count_reg > CW'(1)) begin
                head_reg <= mem[rd_ptr_inc];
            end else if (push && (count_reg == '0 || pop)) begin
                head_reg <= push_data;
            end
        end
    end

    assign head  = head_reg;
    assign valid = (count_reg != '0);
    assign count = count_reg;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues in-order word requests, pairs responses with PCs,
// buffers them toward decode. IFETCH_PERF_CNT_EN adds fetched/discarded counters.
module ifetch_unit #(
    parameter int unsigned           xlen       = ifetch_unit_pkg::xlen,
    parameter logic [xlen-1:0]       RESET_PC   = 32'h0000_0000,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [xlen-1:0] redirect_target,
    input  logic            flush_if,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [xlen-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [xlen-1:0] imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [xlen-1:0] dec_pc,
    output logic [xlen-1:0] dec_instr
`ifdef IFETCH_PERF_CNT_EN
   ,output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_discarded
`endif
);

    import ifetch_unit_pkg::fetch_entry_t;
    import ifetch_unit_pkg::ifetch_state_e;
    import ifetch_unit_pkg::INSTR_BYTES;
    import ifetch_unit_pkg::BOOT;
    import ifetch_unit_pkg::FETCH;
    import ifetch_unit_pkg::DRAIN;

    localparam int unsigned     CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned     SW      = CW + 1;
    localparam logic [SW-1:0]   DEPTH_S = SW'(FIFO_DEPTH);
    localparam logic [xlen-1:0] STEP    = xlen'(INSTR_BYTES);

    ifetch_state_e   state_reg, state_next;
    logic [xlen-1:0] fetch_pc_reg, fetch_pc_next;
    logic [xlen-1:0] rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   discard_cnt_reg, discard_cnt_next;
    logic            req_valid_reg, req_valid_next;
    logic [CW-1:0]   fifo_count, fifo_count_next;
    logic [xlen-1:0] new_pc;
    fetch_entry_t    fifo_head, push_entry;
    logic            fifo_valid, kill, req_fire, push, pop;

    assign kill       = redirect_valid | flush_if;
    assign req_fire   = req_valid_reg & imem_req_ready;
    assign push       = imem_rsp_valid & (state_reg != DRAIN) & ~kill;
    assign pop        = fifo_valid & dec_ready & ~kill;
    assign push_entry = '{pc: rsp_pc_reg, instr: imem_rsp_data};

    always_comb begin
        // Flush restarts at the oldest instruction not yet handed to decode.
        new_pc = redirect_valid ? (redirect_target & ~xlen'(3))
               : (fifo_valid ? fifo_head.pc : rsp_pc_reg);
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
        fifo_count_next  = kill ? '0 : fifo_count + CW'(push) - CW'(pop);
        fetch_pc_next    = kill ? new_pc : (req_fire ? fetch_pc_reg + STEP : fetch_pc_reg);
        rsp_pc_next      = kill ? new_pc : (push ? rsp_pc_reg + STEP : rsp_pc_reg);
        state_next       = state_reg;
        discard_cnt_next = discard_cnt_reg;
        if (kill) begin
            discard_cnt_next = outstanding_next;
            state_next       = (outstanding_next != '0) ? DRAIN : FETCH;
        end else begin
            case (state_reg)
                DRAIN: begin
                    discard_cnt_next = discard_cnt_reg - CW'(imem_rsp_valid);
                    if (discard_cnt_next == '0) state_next = FETCH;
                end
                default: state_next = FETCH;
            endcase
        end
        // Credit rule: every request in flight is guaranteed a FIFO slot.
        req_valid_next = (state_next == FETCH)
                       && (({1'b0, outstanding_next} + {1'b0, fifo_count_next}) < DEPTH_S);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= BOOT;
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            discard_cnt_reg <= '0;
            req_valid_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            fetch_pc_reg    <= fetch_pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            outstanding_reg <= outstanding_next;
            discard_cnt_reg <= discard_cnt_next;
            req_valid_reg   <= req_valid_next;
        end
    end

    ifetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (kill),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head     (fifo_head),
        .valid    (fifo_valid),
        .count    (fifo_count)
    );

    assign imem_req_valid = req_valid_reg;
    assign imem_req_addr  = fetch_pc_reg;
    assign dec_valid      = fifo_valid;
    assign dec_pc         = fifo_head.pc;
    assign dec_instr      = fifo_head.instr;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_reg, perf_discarded_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_reg   <= '0;
            perf_discarded_reg <= '0;
        end else begin
            if (push && perf_fetched_reg != '1) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if (imem_rsp_valid && !push && perf_discarded_reg != '1) begin
                perf_discarded_reg <= perf_discarded_reg + 32'd1;
            end
        end
    end

    assign perf_fetched   = perf_fetched_reg;
    assign perf_discarded = perf_discarded_reg;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: in-order memory model plus a queue-based
// model of the instruction stream delivered to decode.
module tb_ifetch_unit;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk, rst;
    logic        redirect_valid, flush_if;
    logic [31:0] redirect_target;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_pc, dec_instr;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_discarded;
`endif

    ifetch_unit #(
        .xlen      (32),
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .flush_if       (flush_if),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr)
`ifdef IFETCH_PERF_CNT_EN
       ,.perf_fetched   (perf_fetched),
        .perf_discarded (perf_discarded)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          gen;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] dq[$];
    logic [31:0] fire_log[$];
    logic [31:0] deliv_log[$];
    logic [31:0] exp_req;
    int          gen, cyc, last_due;
    bit          boot, applied;
    longint      perf_f_m, perf_d_m;
    int          dec_pct, req_pct, lat_min, lat_max;
    int          n_checks, n_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    function automatic int n_stale();
        int n = 0;
        foreach (pend[i]) if (pend[i].gen != gen) n++;
        return n;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic tick(input bit r, input logic [31:0] t, input bit f, input bit r_on_rsp);
        bit          rr, rsp, kill, fire, pop, found, exp_v;
        logic [31:0] new_pc;
        pend_t       e;
        int          lat, due;
        rsp = (pend.size() != 0) && (pend[0].due <= cyc);
        rr  = r && (!r_on_rsp || rsp);
        kill = rr | f;
        applied = kill;
        redirect_valid  = rr;
        redirect_target = rr ? t : $urandom();
        flush_if        = f;
        dec_ready       = ($urandom_range(99) < dec_pct);
        imem_req_ready  = ($urandom_range(99) < req_pct);
        imem_rsp_valid  = rsp;
        imem_rsp_data   = rsp ? instr_of(pend[0].addr) : $urandom();
`ifdef IFETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, perf_f_m);
        chk("perf_discarded", perf_discarded, perf_d_m);
`endif
        exp_v = !boot && (n_stale() == 0) && (pend.size() + dq.size() < DEPTH);
        chk("req_valid", imem_req_valid, exp_v);
        chk("dec_valid", dec_valid, dq.size() != 0);
        // Oldest undelivered PC: decode queue head, then live in-flight, then next fetch.
        found = 0;
        new_pc = exp_req;
        if (rr) begin
            new_pc = t & ~32'd3;
        end else if (dq.size() != 0) begin
            new_pc = dq[0];
        end else begin
            foreach (pend[i]) if (!found && pend[i].gen == gen) begin
                new_pc = pend[i].addr;
                found  = 1;
            end
        end
        pop = dec_valid && dec_ready && !kill && (dq.size() != 0);
        if (pop) begin
            chk("dec_pc", dec_pc, dq[0]);
            chk("dec_instr", dec_instr, instr_of(dq[0]));
            deliv_log.push_back(dec_pc);
            void'(dq.pop_front());
        end
        fire = imem_req_valid && imem_req_ready;
        if (rsp) begin
            e = pend.pop_front();
            if (e.gen == gen && !kill) begin
                dq.push_back(e.addr);
                perf_f_m++;
            end else begin
                perf_d_m++;
            end
        end
        if (fire) begin
            chk("req_addr", imem_req_addr, exp_req);
            fire_log.push_back(imem_req_addr);
            lat = $urandom_range(lat_max, lat_min);
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            pend.push_back('{addr: exp_req, gen: gen, due: due});
            last_due = due;
            exp_req  = exp_req + 32'd4;
        end
        if (kill) begin
            gen++;
            dq.delete();
            exp_req = new_pc;
        end
        boot = 0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        redirect_valid = 1'b0;
        flush_if = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        dec_ready = 1'b0;
        repeat (n) @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_dec_valid", dec_valid, 1'b0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_dec_instr", dec_instr, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
        chk("rst_perf_f", perf_fetched, 32'h0);
        chk("rst_perf_d", perf_discarded, 32'h0);
`endif
        pend.delete();
        dq.delete();
        gen++;
        exp_req  = RST_PC;
        boot     = 1;
        last_due = cyc;
        perf_f_m = 0;
        perf_d_m = 0;
        rst = 1'b0;
    endtask

    initial begin
        longint snap_d;
        int     rnd;
        n_checks = 0; n_fail = 0; gen = 0; cyc = 0; last_due = 0;
        perf_f_m = 0; perf_d_m = 0; exp_req = RST_PC; boot = 1;
        rst = 1'b1; redirect_valid = 0; redirect_target = 0; flush_if = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; dec_ready = 0;
        @(negedge clk);

        // Streaming with 1-cycle memory
        do_reset(3);
        dec_pct = 100; req_pct = 100; lat_min = 1; lat_max = 1;
        fire_log.delete(); deliv_log.delete();
        repeat (20) tick(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t1_req_seq", at(fire_log, i), 32'(i * 4));
            chk("t1_dec_seq", at(deliv_log, i), 32'(i * 4));
        end

        // Decode stalled: credit limits requests to the FIFO depth
        do_reset(2);
        dec_pct = 0;
        fire_log.delete();
        repeat (12) tick(0, 0, 0, 0);
        chk("t2_nreq", fire_log.size(), DEPTH);
        chk("t2_stalled", imem_req_valid, 1'b0);
        dec_pct = 100;
        fire_log.delete();
        for (int i = 0; i < 20 && fire_log.size() == 0; i++) tick(0, 0, 0, 0);
        chk("t2_resume", at(fire_log, 0), 32'h8);

        // Redirect with two requests in flight
        do_reset(2);
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && pend.size() != 2; i++) tick(0, 0, 0, 0);
        chk("t3_two_inflight", pend.size(), 2);
        snap_d = perf_d_m;
        fire_log.delete(); deliv_log.delete();
        tick(1, 32'h1002, 0, 0);
        for (int i = 0; i < 40 && deliv_log.size() == 0; i++) tick(0, 0, 0, 0);
        chk("t3_first_req", at(fire_log, 0), 32'h1000);
        chk("t3_first_dec", at(deliv_log, 0), 32'h1000);
`ifdef IFETCH_PERF_CNT_EN
        chk("t3_perf_disc", perf_discarded, 32'(snap_d + 2));
`endif

        // Flush with the FIFO holding 0x20 and 0x24
        do_reset(2);
        lat_min = 1; lat_max = 1; dec_pct = 0;
        tick(1, 32'h20, 0, 0);
        for (int i = 0; i < 20 && dq.size() != 2; i++) tick(0, 0, 0, 0);
        chk("t4_head", dec_pc, 32'h20);
        fire_log.delete();
        tick(0, 0, 1, 0);
        chk("t4_empty", dec_valid, 1'b0);
        dec_pct = 100;
        for (int i = 0; i < 20 && fire_log.size() == 0; i++) tick(0, 0, 0, 0);
        chk("t4_refetch", at(fire_log, 0), 32'h20);

        // Redirect coinciding with a response, then address wrap
        do_reset(2);
        tick(1, 32'hFFFF_FFF8, 0, 0);
        applied = 0;
        for (int i = 0; i < 20 && !applied; i++) tick(1, 32'hFFFF_FFFC, 0, 1);
        chk("t5_applied", applied, 1'b1);
        fire_log.delete(); deliv_log.delete();
        for (int i = 0; i < 20 && (fire_log.size() < 2 || deliv_log.size() < 2); i++) tick(0, 0, 0, 0);
        chk("t5_req0", at(fire_log, 0), 32'hFFFF_FFFC);
        chk("t5_req_wrap", at(fire_log, 1), 32'h0);
        chk("t5_dec_wrap", at(deliv_log, 1), 32'h0);

        // Reset while draining with one stale response left
        do_reset(2);
        lat_min = 5; lat_max = 5;
        for (int i = 0; i < 20 && pend.size() == 0; i++) tick(0, 0, 0, 0);
        tick(1, 32'h400, 0, 0);
        for (int i = 0; i < 20 && !(pend.size() == 1 && n_stale() == 1); i++) tick(0, 0, 0, 0);
        chk("t6_drain_one", n_stale(), 1);
        do_reset(2);
        chk("t6_boot_idle", imem_req_valid, 1'b0);
        tick(0, 0, 0, 0);
        chk("t6_req_after_boot", imem_req_valid, 1'b1);
        chk("t6_addr_after_boot", imem_req_addr, RST_PC);

        // Random traffic
        lat_min = 1; lat_max = 4; dec_pct = 70; req_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            rnd = $urandom_range(999);
            if (rnd == 999)     do_reset(1 + $urandom_range(2));
            else if (rnd < 15)  tick(1, $urandom(), 0, 0);
            else if (rnd < 30)  tick(0, 0, 1, 0);
            else if (rnd < 33)  tick(1, $urandom(), 1, 0);
            else                tick(0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
